// File: rtl/ddr_refresh_sequencer_if.sv
// ---------------------------------------------------------------------------
// ddr_refresh_sequencer_if
//
// Groups the signals between the refresh sequencer and its neighbours.
//   Handshake with the refresh requester:
//     want, need        requester -> sequencer (refresh requested / urgent)
//     grant             sequencer -> requester (1-cycle pulse with REFRESH)
//   Command-bus side:
//     bus_idle          arbiter -> sequencer (no other owner/requester)
//     banks_open        bank tracker -> sequencer (some bank is open)
//     hold_rq, bus_own  sequencer -> other sequencers / arbiter
//     cmd_en, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10
//                       sequencer -> DDR3 command path
//
// Modports:
//   master : the environment (requester, arbiter, bank tracker)
//   slave  : the refresh sequencer itself
// ---------------------------------------------------------------------------
interface ddr_refresh_sequencer_if;
  logic want;
  logic need;
  logic grant;
  logic bus_idle;
  logic banks_open;
  logic hold_rq;
  logic bus_own;
  logic cmd_en;
  logic cmd_ras_n;
  logic cmd_cas_n;
  logic cmd_we_n;
  logic cmd_a10;

  modport master (
    output want,
    output need,
    output bus_idle,
    output banks_open,
    input  grant,
    input  hold_rq,
    input  bus_own,
    input  cmd_en,
    input  cmd_ras_n,
    input  cmd_cas_n,
    input  cmd_we_n,
    input  cmd_a10
  );

  modport slave (
    input  want,
    input  need,
    input  bus_idle,
    input  banks_open,
    output grant,
    output hold_rq,
    output bus_own,
    output cmd_en,
    output cmd_ras_n,
    output cmd_cas_n,
    output cmd_we_n,
    output cmd_a10
  );
endinterface

// File: rtl/ddr_refresh_sequencer.sv
// ---------------------------------------------------------------------------
// ddr_refresh_sequencer
//
// Refresh responder for the DDR3 controller. On a refresh request it waits
// for the command bus to go idle, takes ownership, issues PRECHARGE-ALL when
// any bank is open, waits tRP, issues AUTO-REFRESH (pulsing grant in the same
// cycle), waits tRFC and then releases the bus.
//
// Ports:
//   clk     controller clock, everything on the rising edge
//   mrst_n  synchronous active-low reset (aborts any sequence at once)
//   en      enable; 0 blocks new sequences, a running one still completes
//   trp     PRECHARGE-to-REFRESH wait in cycles (1..max)
//   trfc    REFRESH-to-release wait in cycles (2..max, smaller is clamped)
//   rq      ddr_refresh_sequencer_if.slave: want/need/grant handshake,
//           bus_idle/banks_open inputs, hold_rq/bus_own and the registered
//           DDR3 command outputs
//
// Optional feature (compile-time macro DDR_REFRESH_BURST_EN):
//   defined   - at the end of tRFC, if en && want && need, a further REFRESH
//               is issued immediately while keeping the bus.
//   undefined - every refresh returns to IDLE and re-arbitrates for the bus.
//
// All outputs are registered: each output value is set on the same edge that
// enters the state it belongs to.
// ---------------------------------------------------------------------------
module ddr_refresh_sequencer #(
  parameter int TRP_W  = 4,
  parameter int TRFC_W = 8
) (
  input  logic                 clk,
  input  logic                 mrst_n,
  input  logic                 en,
  input  logic [TRP_W-1:0]     trp,
  input  logic [TRFC_W-1:0]    trfc,
  ddr_refresh_sequencer_if.slave rq
);

  // One counter serves both waits, so it is sized for the wider of the two.
  localparam int CNT_W = (TRFC_W > TRP_W) ? TRFC_W : TRP_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUS = 3'd1,
    S_PRE      = 3'd2,
    S_TRP      = 3'd3,
    S_REF      = 3'd4,
    S_TRFC     = 3'd5
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  trp_load;
  logic [CNT_W-1:0]  trfc_load;

  // The counter is loaded with (wait - 1) on leaving PRE/REF and the wait
  // state exits on the edge where it reads 0, giving exactly `wait` cycles of
  // NOP. trp=0 is treated as 1 and trfc<2 as 2 so the load never wraps and a
  // requester dropping want 2 cycles after grant can never retrigger.
  always_comb begin
    trp_load  = '0;
    trfc_load = CNT_W'(1);
    if (trp != '0) begin
      trp_load = CNT_W'(trp) - CNT_W'(1);
    end
    if (trfc >= TRFC_W'(2)) begin
      trfc_load = CNT_W'(trfc) - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!mrst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      rq.grant     <= 1'b0;
      rq.hold_rq   <= 1'b0;
      rq.bus_own   <= 1'b0;
      rq.cmd_en    <= 1'b0;
      rq.cmd_ras_n <= 1'b1;
      rq.cmd_cas_n <= 1'b1;
      rq.cmd_we_n  <= 1'b1;
      rq.cmd_a10   <= 1'b0;
    end else begin
      // Commands and grant are single-cycle: default every cycle to NOP and
      // let the transition into PRE/REF override.
      rq.grant     <= 1'b0;
      rq.cmd_en    <= 1'b0;
      rq.cmd_ras_n <= 1'b1;
      rq.cmd_cas_n <= 1'b1;
      rq.cmd_we_n  <= 1'b1;
      rq.cmd_a10   <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          rq.hold_rq <= 1'b0;
          if (en && rq.want) begin
            state_reg <= S_WAIT_BUS;
          end
        end

        S_WAIT_BUS: begin
          // hold_rq tracks need while waiting; once the bus is taken it keeps
          // the value sampled here until the sequence releases the bus.
          rq.hold_rq <= rq.need;
          if (!rq.want || (!en && !rq.need)) begin
            // Requester withdrew, or disabled without urgency: give up.
            state_reg  <= S_IDLE;
            rq.hold_rq <= 1'b0;
          end else if (rq.bus_idle) begin
            rq.bus_own <= 1'b1;
            if (rq.banks_open) begin
              // PRECHARGE-ALL
              state_reg    <= S_PRE;
              rq.cmd_en    <= 1'b1;
              rq.cmd_ras_n <= 1'b0;
              rq.cmd_cas_n <= 1'b1;
              rq.cmd_we_n  <= 1'b0;
              rq.cmd_a10   <= 1'b1;
            end else begin
              // Banks already closed: straight to AUTO-REFRESH
              state_reg    <= S_REF;
              rq.cmd_en    <= 1'b1;
              rq.cmd_ras_n <= 1'b0;
              rq.cmd_cas_n <= 1'b0;
              rq.cmd_we_n  <= 1'b1;
              rq.grant     <= 1'b1;
            end
          end
        end

        S_PRE: begin
          state_reg <= S_TRP;
          cnt_reg   <= trp_load;
        end

        S_TRP: begin
          if (cnt_reg == '0) begin
            state_reg    <= S_REF;
            rq.cmd_en    <= 1'b1;
            rq.cmd_ras_n <= 1'b0;
            rq.cmd_cas_n <= 1'b0;
            rq.cmd_we_n  <= 1'b1;
            rq.grant     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_REF: begin
          state_reg <= S_TRFC;
          cnt_reg   <= trfc_load;
        end

        S_TRFC: begin
          if (cnt_reg == '0) begin
`ifdef DDR_REFRESH_BURST_EN
            if (en && rq.want && rq.need) begin
              // Backlog: refresh again without giving up the bus. Banks are
              // known closed because a REFRESH was just completed.
              state_reg    <= S_REF;
              rq.cmd_en    <= 1'b1;
              rq.cmd_ras_n <= 1'b0;
              rq.cmd_cas_n <= 1'b0;
              rq.cmd_we_n  <= 1'b1;
              rq.grant     <= 1'b1;
              rq.hold_rq   <= 1'b1;
            end else begin
              state_reg  <= S_IDLE;
              rq.bus_own <= 1'b0;
              rq.hold_rq <= 1'b0;
            end
`else
            state_reg  <= S_IDLE;
            rq.bus_own <= 1'b0;
            rq.hold_rq <= 1'b0;
`endif
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        default: begin
          state_reg  <= S_IDLE;
          rq.bus_own <= 1'b0;
          rq.hold_rq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_refresh_sequencer.sv
module tb_ddr_refresh_sequencer;

  logic       clk;
  logic       mrst_n;
  logic       en;
  logic [3:0] trp;
  logic [7:0] trfc;

  ddr_refresh_sequencer_if rq_if ();

  ddr_refresh_sequencer #(.TRP_W(4), .TRFC_W(8)) dut (
    .clk    (clk),
    .mrst_n (mrst_n),
    .en     (en),
    .trp    (trp),
    .trfc   (trfc),
    .rq     (rq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int gcount = 0;
  int nseq   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  // and new inputs take effect at the following edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_cmd_en"}, rq_if.cmd_en, 0);
    chk({tag, "_grant"},  rq_if.grant, 0);
    chk({tag, "_ras"},    rq_if.cmd_ras_n, 1);
    chk({tag, "_cas"},    rq_if.cmd_cas_n, 1);
    chk({tag, "_we"},     rq_if.cmd_we_n, 1);
    chk({tag, "_a10"},    rq_if.cmd_a10, 0);
  endtask

  // One complete refresh from IDLE. Expected timeline, counted in edges
  // from the edge that sees bus_idle in WAIT_BUS (k=0):
  //   PRE at 0 (if banks open), REF at trp+1 (or 0), release trfc+1 later.
  task automatic run_seq(input int trp_v, input int trfc_v, input bit banks,
                         input int dly, input bit nd);
    int te, r, rel, ref_seen;
    bit is_pre, is_ref;
    te  = (trfc_v < 2) ? 2 : trfc_v;
    r   = banks ? trp_v + 1 : 0;
    rel = r + te + 1;
    ref_seen = -1;
    trp  = 4'(trp_v);
    trfc = 8'(trfc_v);
    rq_if.banks_open = banks;
    rq_if.need       = nd;
    rq_if.bus_idle   = 1'b0;
    rq_if.want       = 1'b1;
    en               = 1'b1;
    tick;
    chk("enter_wait_own", rq_if.bus_own, 0);
    chk_nop("enter_wait");
    for (int i = 0; i < dly; i++) begin
      tick;
      chk_nop("bus_busy");
      chk("bus_busy_own", rq_if.bus_own, 0);
      chk("bus_busy_hold", rq_if.hold_rq, nd);
    end
    rq_if.bus_idle = 1'b1;
    for (int k = 0; k <= rel; k++) begin
      tick;
      is_pre = banks && (k == 0);
      is_ref = (k == r);
      if (rq_if.grant === 1'b1) begin
        gcount++;
        ref_seen = k;
      end
      chk("seq_grant",  rq_if.grant, is_ref);
      chk("seq_cmd_en", rq_if.cmd_en, is_pre || is_ref);
      chk("seq_ras",    rq_if.cmd_ras_n, !(is_pre || is_ref));
      chk("seq_cas",    rq_if.cmd_cas_n, !is_ref);
      chk("seq_we",     rq_if.cmd_we_n, !is_pre);
      chk("seq_a10",    rq_if.cmd_a10, is_pre);
      chk("seq_own",    rq_if.bus_own, k < rel);
      chk("seq_hold",   rq_if.hold_rq, (k < rel) ? nd : 1'b0);
      // en may drop mid-sequence; the sequence must still complete.
      if (k == 0) en = 1'($urandom_range(0, 1));
      // Requester behaviour: want drops 2 cycles after grant.
      if (k == r + 2) rq_if.want = 1'b0;
    end
    rq_if.bus_idle = 1'b0;
    nseq++;
    $display("seq %0d: trp=%0d trfc=%0d banks=%0d dly=%0d need=%0d ref_at=%0d release_at=%0d",
             nseq, trp_v, trfc_v, banks, dly, nd, ref_seen, rel);
  endtask

  // Let any running sequence finish; bounded so a stuck DUT cannot hang.
  task automatic drain(input string tag);
    int n;
    n = 0;
    rq_if.want = 1'b0;
    rq_if.need = 1'b0;
    while (rq_if.bus_own !== 1'b0 && n < 200) begin
      tick;
      n++;
    end
    chk(tag, rq_if.bus_own, 0);
    tick;
    tick;
  endtask

  initial begin
    // ---------------- reset ----------------
    mrst_n = 1'b0;
    en = 1'b1;
    trp = 4'd3;
    trfc = 8'd4;
    rq_if.want = 1'b1;
    rq_if.need = 1'b0;
    rq_if.bus_idle = 1'b1;
    rq_if.banks_open = 1'b0;
    tick;
    tick;
    tick;
    chk_nop("reset");
    chk("reset_own", rq_if.bus_own, 0);
    chk("reset_hold", rq_if.hold_rq, 0);
    mrst_n = 1'b1;
    // release -> WAIT_BUS next edge, REF with grant on the edge after
    run_seq(3, 4, 1'b0, 0, 1'b0);
    $display("reset release: refresh issued 2 cycles after release");

    // ---------------- precharge path ----------------
    run_seq(3, 10, 1'b1, 0, 1'b0);

    // ---------------- bus contention ----------------
    run_seq(2, 6, 1'b1, 20, 1'b0);
    run_seq(2, 6, 1'b0, 5, 1'b1);

    // ---------------- illegal/boundary trfc, trp=1 ----------------
    run_seq(1, 0, 1'b1, 0, 1'b0);
    run_seq(1, 1, 1'b0, 1, 1'b0);
    run_seq(15, 255, 1'b1, 2, 1'b1);

    // ---------------- requester loop, trfc=2 ----------------
    for (int i = 0; i < 6; i++) begin
      run_seq(1, 2, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end

    // ---------------- randomized sequences ----------------
    for (int i = 0; i < 16; i++) begin
      run_seq($urandom_range(1, 15), $urandom_range(0, 30),
              1'($urandom_range(0, 1)), $urandom_range(0, 6),
              1'($urandom_range(0, 1)));
    end
    chk("grant_count", gcount, nseq);

    // ---------------- want drops while waiting for the bus ----------------
    en = 1'b1;
    rq_if.want = 1'b1;
    rq_if.need = 1'b1;
    rq_if.bus_idle = 1'b0;
    tick;
    tick;
    chk("wait_need_hold", rq_if.hold_rq, 1);
    rq_if.want = 1'b0;
    tick;
    chk("want_drop_hold", rq_if.hold_rq, 0);
    rq_if.bus_idle = 1'b1;
    tick;
    chk("want_drop_own", rq_if.bus_own, 0);
    chk_nop("want_drop");
    rq_if.need = 1'b0;
    rq_if.bus_idle = 1'b0;
    $display("want withdrawn in WAIT_BUS: sequence abandoned");

    // ---------------- en=0 in WAIT_BUS ----------------
    rq_if.want = 1'b1;
    en = 1'b1;
    tick;
    en = 1'b0;
    tick;
    rq_if.bus_idle = 1'b1;
    tick;
    chk("en_off_own", rq_if.bus_own, 0);
    chk_nop("en_off");
    rq_if.bus_idle = 1'b0;
    en = 1'b1;
    tick;
    en = 1'b0;
    rq_if.need = 1'b1;
    tick;
    chk("en_off_need_hold", rq_if.hold_rq, 1);
    rq_if.bus_idle = 1'b1;
    rq_if.banks_open = 1'b0;
    tick;
    chk("en_off_need_own", rq_if.bus_own, 1);
    chk("en_off_need_grant", rq_if.grant, 1);
    drain("en_off_drain");
    $display("en=0 with need=1: refresh still taken");

    // ---------------- reset abort during TRP ----------------
    en = 1'b1;
    trp = 4'd8;
    trfc = 8'd4;
    rq_if.want = 1'b1;
    rq_if.banks_open = 1'b1;
    rq_if.bus_idle = 1'b1;
    tick;
    tick;
    chk("abort_pre_cmd", rq_if.cmd_en, 1);
    chk("abort_pre_a10", rq_if.cmd_a10, 1);
    rq_if.want = 1'b0;
    tick;
    mrst_n = 1'b0;
    tick;
    chk_nop("abort");
    chk("abort_own", rq_if.bus_own, 0);
    chk("abort_hold", rq_if.hold_rq, 0);
    tick;
    chk_nop("abort_hold_rst");
    mrst_n = 1'b1;
    tick;
    chk_nop("abort_after");
    chk("abort_after_own", rq_if.bus_own, 0);
    $display("reset abort during TRP: no REFRESH issued");

    // ---------------- back-to-back demand ----------------
    begin
      int period;
`ifdef DDR_REFRESH_BURST_EN
      period = 6;
`else
      period = 8;
`endif
      en = 1'b1;
      trfc = 8'd5;
      rq_if.banks_open = 1'b0;
      rq_if.bus_idle = 1'b1;
      rq_if.want = 1'b1;
      rq_if.need = 1'b1;
      tick;
      for (int k = 0; k < 24; k++) begin
        tick;
        chk("burst_grant", rq_if.grant, (k % period) == 0);
`ifdef DDR_REFRESH_BURST_EN
        chk("burst_own", rq_if.bus_own, 1);
`else
        chk("burst_own", rq_if.bus_own, (k % 8) < 6);
`endif
      end
      $display("continuous demand: expected grant spacing %0d cycles", period);
      drain("burst_drain");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
